control_campos_prog: RTL and testbench

Upstream control stage for the date/time programming path. It synchronizes and debounces the raw programming switch and the four push buttons. It tracks which time/date field is being edited and drives the field code `en_count`, plus `enUP`/`enDOWN` pulses with auto-repeat. All per-field BCD counters, including the month counter, consume these outputs.

---
 rtl/control_campos_prog_pkg.sv | 26 ++
 rtl/control_campos_prog_antirrebote.sv | 60 ++++++
 rtl/control_campos_prog.sv | 178 +++++++++++++++++
 tb/tb_control_campos_prog.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/control_campos_prog_pkg.sv
// Shared definitions for the date/time programming control path:
// field codes, FSM state type and counter sizing helper.
package control_campos_prog_pkg;

  localparam logic [3:0] FIELD_NONE    = 4'd0;
  localparam logic [3:0] FIELD_SECONDS = 4'd1;
  localparam logic [3:0] FIELD_MINUTES = 4'd2;
  localparam logic [3:0] FIELD_HOURS   = 4'd3;
  localparam logic [3:0] FIELD_DAY     = 4'd4;
  // Must match the month counter's select value.
  localparam logic [3:0] FIELD_MONTH   = 4'd5;
  localparam logic [3:0] FIELD_YEAR    = 4'd6;

  localparam logic [3:0] FIELD_MIN = FIELD_SECONDS;
  localparam logic [3:0] FIELD_MAX = FIELD_YEAR;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EDIT = 1'b1
  } state_t;

  function automatic int cnt_width(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/control_campos_prog_antirrebote.sv
// 2-FF synchronizer plus run-length debouncer; emits the debounced level
// and a one-cycle pulse in the cycle the debounced level rises.
module antirrebote
  import control_campos_prog_pkg::*;
#(
  parameter int DEB_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_i,
  output logic level_o,
  output logic rise_o
);

  localparam int CW = cnt_width(DEB_CYCLES);

  logic          sync0_q, sync1_q;
  logic          deb_q, deb_d;
  logic          rise_q, rise_d;
  logic [CW-1:0] run_q, run_d;

  // The run counter only advances while the synchronized input disagrees
  // with the debounced level; any agreeing cycle restarts it.
  always_comb begin
    deb_d  = deb_q;
    rise_d = 1'b0;
    run_d  = '0;
    if (sync1_q != deb_q) begin
      if (run_q == CW'(DEB_CYCLES - 1)) begin
        deb_d  = sync1_q;
        rise_d = sync1_q;
        run_d  = '0;
      end else if (run_q != '1) begin
        run_d = run_q + CW'(1);
      end else begin
        run_d = run_q;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync0_q <= 1'b0;
      sync1_q <= 1'b0;
      deb_q   <= 1'b0;
      rise_q  <= 1'b0;
      run_q   <= '0;
    end else begin
      sync0_q <= raw_i;
      sync1_q <= sync0_q;
      deb_q   <= deb_d;
      rise_q  <= rise_d;
      run_q   <= run_d;
    end
  end

  assign level_o = deb_q;
  assign rise_o  = rise_q;

endmodule

// File: rtl/control_campos_prog.sv
// Programming-path control: conditions the switch and buttons, tracks the
// field under edit and generates enUP/enDOWN pulses with auto-repeat.
module control_campos_prog
  import control_campos_prog_pkg::*;
#(
  parameter int DEB_CYCLES = 500000,
  parameter int REP_DELAY  = 50000000,
  parameter int REP_PERIOD = 10000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sw_prog,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_up,
  input  logic       btn_down,
  output logic [3:0] en_count,
  output logic       enUP,
  output logic       enDOWN,
  output logic       prog_mode,
  output state_t     dbg_state_o
);

  localparam int RW_D = cnt_width(REP_DELAY);
  localparam int RW_P = cnt_width(REP_PERIOD);
  localparam int RW   = (RW_D > RW_P) ? RW_D : RW_P;

  logic sw_lvl, left_rise, right_rise, up_lvl, up_rise, dn_lvl, dn_rise;
  logic sw_rise_unused, left_lvl_unused, right_lvl_unused;

  antirrebote #(.DEB_CYCLES(DEB_CYCLES)) u_deb_sw (
    .clk(clk), .reset(reset), .raw_i(sw_prog),
    .level_o(sw_lvl), .rise_o(sw_rise_unused)
  );
  antirrebote #(.DEB_CYCLES(DEB_CYCLES)) u_deb_left (
    .clk(clk), .reset(reset), .raw_i(btn_left),
    .level_o(left_lvl_unused), .rise_o(left_rise)
  );
  antirrebote #(.DEB_CYCLES(DEB_CYCLES)) u_deb_right (
    .clk(clk), .reset(reset), .raw_i(btn_right),
    .level_o(right_lvl_unused), .rise_o(right_rise)
  );
  antirrebote #(.DEB_CYCLES(DEB_CYCLES)) u_deb_up (
    .clk(clk), .reset(reset), .raw_i(btn_up),
    .level_o(up_lvl), .rise_o(up_rise)
  );
  antirrebote #(.DEB_CYCLES(DEB_CYCLES)) u_deb_down (
    .clk(clk), .reset(reset), .raw_i(btn_down),
    .level_o(dn_lvl), .rise_o(dn_rise)
  );

  state_t        state_q, state_d;
  logic [3:0]    field_q, field_d;
  logic          up_q, up_d, dn_q, dn_d, prog_q, prog_d;
  logic          rep_act_q, rep_act_d;
  logic          rep_up_q, rep_up_d;
  logic          rep_first_q, rep_first_d;
  logic          lock_q, lock_d;
  logic [RW-1:0] rep_cnt_q, rep_cnt_d;
  logic [RW-1:0] rep_target;
  logic          rep_held;

  assign rep_target = rep_first_q ? RW'(REP_DELAY) : RW'(REP_PERIOD);
  assign rep_held   = rep_up_q ? up_lvl : dn_lvl;

  always_comb begin
    state_d     = state_q;
    field_d     = field_q;
    up_d        = 1'b0;
    dn_d        = 1'b0;
    rep_act_d   = rep_act_q;
    rep_up_d    = rep_up_q;
    rep_first_d = rep_first_q;
    rep_cnt_d   = rep_cnt_q;
    lock_d      = lock_q;
    case (state_q)
      ST_IDLE: begin
        field_d   = FIELD_NONE;
        rep_act_d = 1'b0;
        rep_cnt_d = '0;
        lock_d    = 1'b0;
        if (sw_lvl) begin
          state_d = ST_EDIT;
          field_d = FIELD_MIN;
        end
      end
      ST_EDIT: begin
        if (!sw_lvl) begin
          state_d   = ST_IDLE;
          field_d   = FIELD_NONE;
          rep_act_d = 1'b0;
          rep_cnt_d = '0;
          lock_d    = 1'b0;
        end else begin
          if (right_rise && !left_rise) begin
            field_d = (field_q == FIELD_MAX) ? FIELD_MIN : field_q + 4'd1;
          end else if (left_rise && !right_rise) begin
            field_d = (field_q == FIELD_MIN) ? FIELD_MAX : field_q - 4'd1;
          end
          // lock_q blocks pulses until both up and down have been released.
          if (up_lvl && dn_lvl) begin
            rep_act_d = 1'b0;
            rep_cnt_d = '0;
            lock_d    = 1'b1;
          end else if (lock_q) begin
            if (!up_lvl && !dn_lvl) lock_d = 1'b0;
          end else if ((left_rise || right_rise) && (up_lvl || dn_lvl)) begin
            rep_act_d = 1'b0;
            rep_cnt_d = '0;
            lock_d    = 1'b1;
          end else if (up_rise) begin
            up_d        = 1'b1;
            rep_act_d   = 1'b1;
            rep_up_d    = 1'b1;
            rep_first_d = 1'b1;
            rep_cnt_d   = '0;
          end else if (dn_rise) begin
            dn_d        = 1'b1;
            rep_act_d   = 1'b1;
            rep_up_d    = 1'b0;
            rep_first_d = 1'b1;
            rep_cnt_d   = '0;
          end else if (rep_act_q) begin
            if (!rep_held) begin
              rep_act_d = 1'b0;
              rep_cnt_d = '0;
            end else if (rep_cnt_q + RW'(1) == rep_target) begin
              up_d        = rep_up_q;
              dn_d        = !rep_up_q;
              rep_first_d = 1'b0;
              rep_cnt_d   = '0;
            end else if (rep_cnt_q != '1) begin
              rep_cnt_d = rep_cnt_q + RW'(1);
            end
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        field_d = FIELD_NONE;
      end
    endcase
    prog_d = (state_d == ST_EDIT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      field_q     <= FIELD_NONE;
      up_q        <= 1'b0;
      dn_q        <= 1'b0;
      prog_q      <= 1'b0;
      rep_act_q   <= 1'b0;
      rep_up_q    <= 1'b0;
      rep_first_q <= 1'b0;
      rep_cnt_q   <= '0;
      lock_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      field_q     <= field_d;
      up_q        <= up_d;
      dn_q        <= dn_d;
      prog_q      <= prog_d;
      rep_act_q   <= rep_act_d;
      rep_up_q    <= rep_up_d;
      rep_first_q <= rep_first_d;
      rep_cnt_q   <= rep_cnt_d;
      lock_q      <= lock_d;
    end
  end

  assign en_count    = field_q;
  assign enUP        = up_q;
  assign enDOWN      = dn_q;
  assign prog_mode   = prog_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_control_campos_prog.sv
// Bench for control_campos_prog with short debounce/repeat parameters.
module tb_control_campos_prog;
  import control_campos_prog_pkg::*;

  localparam int D  = 4;
  localparam int RD = 20;
  localparam int RP = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] raw;  // 0 sw, 1 left, 2 right, 3 up, 4 down
  logic [3:0] en_count;
  logic       enUP, enDOWN, prog_mode;
  state_t     dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  control_campos_prog #(.DEB_CYCLES(D), .REP_DELAY(RD), .REP_PERIOD(RP)) dut (
    .clk(clk), .reset(reset), .sw_prog(raw[0]), .btn_left(raw[1]),
    .btn_right(raw[2]), .btn_up(raw[3]), .btn_down(raw[4]),
    .en_count(en_count), .enUP(enUP), .enDOWN(enDOWN),
    .prog_mode(prog_mode), .dbg_state_o(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // Debounced level flips when the last D synchronized samples all disagree
  // with it; outputs react to the debounced view one edge later.
  logic [7:0] hist [5];
  logic       m_deb [5];
  logic       m_rise [5];
  int         ncyc;
  bit         m_edit, m_lock;
  int         m_rep;      // 0 none, 1 up, 2 down
  int         m_next_at;
  int         e_field;
  bit         e_up, e_dn, e_prog;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < 5; k++) begin
        hist[k] = '0; m_deb[k] = 1'b0; m_rise[k] = 1'b0;
      end
      ncyc = 0; m_edit = 0; m_lock = 0; m_rep = 0; m_next_at = 0;
      e_field = 0; e_up = 0; e_dn = 0; e_prog = 0;
    end else begin
      ncyc++;
      e_up = 0; e_dn = 0;
      if (!m_edit) begin
        e_field = 0; m_rep = 0; m_lock = 0;
        if (m_deb[0]) begin m_edit = 1; e_field = 1; end
      end else if (!m_deb[0]) begin
        m_edit = 0; e_field = 0; m_rep = 0; m_lock = 0;
      end else begin
        if (m_rise[2] && !m_rise[1]) e_field = (e_field == 6) ? 1 : e_field + 1;
        else if (m_rise[1] && !m_rise[2]) e_field = (e_field == 1) ? 6 : e_field - 1;
        if (m_deb[3] && m_deb[4]) begin
          m_rep = 0; m_lock = 1;
        end else if (m_lock) begin
          if (!m_deb[3] && !m_deb[4]) m_lock = 0;
        end else if ((m_rise[1] || m_rise[2]) && (m_deb[3] || m_deb[4])) begin
          m_rep = 0; m_lock = 1;
        end else if (m_rise[3]) begin
          e_up = 1; m_rep = 1; m_next_at = ncyc + RD;
        end else if (m_rise[4]) begin
          e_dn = 1; m_rep = 2; m_next_at = ncyc + RD;
        end else if (m_rep != 0) begin
          if (!(m_rep == 1 ? m_deb[3] : m_deb[4])) m_rep = 0;
          else if (ncyc == m_next_at) begin
            if (m_rep == 1) e_up = 1; else e_dn = 1;
            m_next_at = ncyc + RP;
          end
        end
      end
      e_prog = m_edit;
      for (int k = 0; k < 5; k++) begin
        bit agree;
        agree = 0;
        for (int j = 1; j <= D; j++) if (hist[k][j] == m_deb[k]) agree = 1;
        m_rise[k] = 1'b0;
        if (!agree) begin
          m_deb[k]  = ~m_deb[k];
          m_rise[k] = m_deb[k];
        end
        hist[k] = {hist[k][6:0], raw[k]};
      end
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    n_checks++;
    if (en_count !== 4'(e_field) || enUP !== e_up || enDOWN !== e_dn ||
        prog_mode !== e_prog) begin
      n_errors++;
      $display("FAIL model_cycle t=%0t got en_count=%0d up=%b dn=%b prog=%b exp en_count=%0d up=%b dn=%b prog=%b",
               $time, en_count, enUP, enDOWN, prog_mode, e_field, e_up, e_dn, e_prog);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d exp %0d", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input int idx);
    raw[idx] = 1'b1;
    cycles(8);
    raw[idx] = 1'b0;
    cycles(10);
  endtask

  task automatic wait_pulse(input bit down, input string name);
    bit ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (down ? enDOWN : enUP) ok = 1;
    end
    check(name, int'(ok), 1);
  endtask

  // counts pulses seen at the next n negedges
  task automatic count_pulses(input int n, output int ups, output int dns);
    ups = 0; dns = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (enUP) ups++;
      if (enDOWN) dns++;
    end
  endtask

  // ---------------- scoreboard for auto-repeat offsets ----------------
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  initial begin
    int ups, dns;
    reset = 1'b1;
    raw   = '0;
    cycles(3);
    check("reset_en_count", en_count, 0);
    check("reset_enUP", enUP, 0);
    check("reset_prog_mode", prog_mode, 0);
    reset = 1'b0;

    // enter EDIT: valid at edge 7 after raw change
    raw[0] = 1'b1;
    cycles(6);
    check("prog_before_edge7", prog_mode, 0);
    cycles(1);
    check("prog_at_edge7", prog_mode, 1);
    check("field_at_edge7", en_count, 1);
    check("dbg_state_edit", int'(dbg_state), int'(ST_EDIT));

    // 3-cycle glitch is filtered
    raw[2] = 1'b1; cycles(3); raw[2] = 1'b0; cycles(12);
    check("glitch_right", en_count, 1);

    // navigation wrap cases
    repeat (5) press(2);
    check("right_to_6", en_count, 6);
    press(2);
    check("wrap_6_to_1", en_count, 1);
    press(1);
    check("wrap_1_to_6", en_count, 6);
    press(2);
    repeat (4) press(2);
    check("right4_to_5", en_count, 5);

    // hold up: pulses at offsets 0,20,28,36,44
    exp_q = '{8'd0, 8'd20, 8'd28, 8'd36, 8'd44};
    raw[3] = 1'b1;
    wait_pulse(1'b0, "first_up_pulse");
    got_q.push_back(8'd0);
    dns = 0;
    for (int off = 1; off <= 45; off++) begin
      @(negedge clk);
      if (enUP) got_q.push_back(8'(off));
      if (enDOWN) dns++;
    end
    check("hold_up_pulse_count", got_q.size(), exp_q.size());
    while (exp_q.size() > 0 && got_q.size() > 0)
      check("hold_up_offset", got_q.pop_front(), exp_q.pop_front());
    check("hold_up_no_down", dns, 0);
    check("hold_up_field", en_count, 5);
    raw[3] = 1'b0;
    cycles(12);

    // up held then down pressed: everything stops
    raw[3] = 1'b1;
    wait_pulse(1'b0, "up_before_both");
    raw[4] = 1'b1;
    count_pulses(40, ups, dns);
    check("both_held_pulses", ups + dns, 0);
    raw[3] = 1'b0; raw[4] = 1'b0;
    cycles(12);
    raw[4] = 1'b1;
    count_pulses(10, ups, dns);
    raw[4] = 1'b0;
    begin
      int u2, d2;
      count_pulses(12, u2, d2);
      check("fresh_down_count", dns + d2, 1);
      check("fresh_down_no_up", ups + u2, 0);
    end

    // field change cancels repeat
    raw[3] = 1'b1;
    wait_pulse(1'b0, "up_before_right");
    raw[2] = 1'b1;
    count_pulses(8, ups, dns);
    raw[2] = 1'b0;
    begin
      int u2, d2;
      count_pulses(32, u2, d2);
      check("cancel_no_repeat", ups + u2 + dns + d2, 0);
    end
    check("cancel_field_advanced", en_count, 6);
    raw[3] = 1'b0;
    cycles(10);
    raw[0] = 1'b0;
    count_pulses(10, ups, dns);
    check("idle_en_count", en_count, 0);
    check("idle_prog_mode", prog_mode, 0);
    check("idle_no_pulses", ups + dns, 0);

    // async reset mid-repeat
    raw[0] = 1'b1;
    cycles(10);
    check("reenter_field", en_count, 1);
    raw[3] = 1'b1;
    wait_pulse(1'b0, "up_before_reset");
    cycles(22);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("async_rst_en_count", en_count, 0);
    check("async_rst_prog", prog_mode, 0);
    check("async_rst_pulses", int'(enUP) + int'(enDOWN), 0);
    count_pulses(4, ups, dns);
    check("during_rst_pulses", ups + dns, 0);
    reset = 1'b0;
    cycles(12);
    check("after_rst_edit", prog_mode, 1);
    cycles(20);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
